// File: rtl/mc_ctrl_pkg.sv
// Shared types, state encoding, opcodes and mux-select encodings for the multicycle controller.
// The optional BNE state is compiled in when MC_CONTROLLER_BNE_EN is defined.
package mc_ctrl_pkg;

    typedef logic       u1;
    typedef logic [1:0] u2;
    typedef logic [3:0] u4;
    typedef logic [5:0] u6;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
`ifdef MC_CONTROLLER_BNE_EN
        , S_BNE   = 4'd12
`endif
    } state_t;

    localparam u6 OP_RTYPE = 6'b000000;
    localparam u6 OP_LW    = 6'b100011;
    localparam u6 OP_SW    = 6'b101011;
    localparam u6 OP_BEQ   = 6'b000100;
    localparam u6 OP_BNE   = 6'b000101;
    localparam u6 OP_ADDI  = 6'b001000;
    localparam u6 OP_J     = 6'b000010;

    localparam u2 ALUSRCB_B     = 2'b00;
    localparam u2 ALUSRCB_FOUR  = 2'b01;
    localparam u2 ALUSRCB_IMM   = 2'b10;
    localparam u2 ALUSRCB_IMMSH = 2'b11;

    localparam u2 PCSRC_ALU    = 2'b00;
    localparam u2 PCSRC_ALUOUT = 2'b01;
    localparam u2 PCSRC_JUMP   = 2'b10;

    localparam u2 ALUOP_ADD   = 2'b00;
    localparam u2 ALUOP_SUB   = 2'b01;
    localparam u2 ALUOP_FUNCT = 2'b10;

    // True for every opcode the DECODE state knows how to dispatch.
    function automatic u1 op_supported(input u6 op);
        u1 ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef MC_CONTROLLER_BNE_EN
            OP_BNE:                                        ok = 1'b1;
`endif
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control table for the multicycle controller.
// While reset is low the table shows FETCH with all write enables and the illegal flag suppressed.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        zero,
    output logic        iord,
    output logic        irwrite,
    output logic        memwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [1:0]  aluop,
    output logic        pcen,
    output logic        illegal
);

    state_t dec_state;
    logic   irwrite_raw;
    logic   pcwrite;
    logic   branch;
    logic   cond;

    // Moore output table; pcen combines pcwrite with the branch condition.
    always_comb begin
        iord        = 1'b0;
        irwrite_raw = 1'b0;
        memwrite    = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = ALUSRCB_B;
        pcsrc       = PCSRC_ALU;
        aluop       = ALUOP_ADD;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        cond        = 1'b0;
        illegal     = 1'b0;
        if (reset) begin
            dec_state = state;
        end else begin
            dec_state = S_FETCH;
        end
        case (dec_state)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                alusrcb     = ALUSRCB_FOUR;
                pcwrite     = 1'b1;
            end
            S_DECODE: begin
                alusrcb = ALUSRCB_IMMSH;
                illegal = ~op_supported(op);
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                cond    = zero;
            end
`ifdef MC_CONTROLLER_BNE_EN
            S_BNE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = 1'b1;
                cond    = ~zero;
            end
`endif
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: begin
                iord = 1'b0;
            end
        endcase
        irwrite = irwrite_raw & reset;
        pcen    = (pcwrite | (branch & cond)) & reset;
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller: state register, next-state logic and the output decoder.
// Define MC_CONTROLLER_BNE_EN to add the BNE branch state.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        zero,
    output logic        iord,
    output logic        irwrite,
    output logic        memwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [1:0]  aluop,
    output logic        pcen,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t cur_state;
    state_t nxt_state;

    // State register; a low reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic; op is only consulted in DECODE and MEMADR.
    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH: nxt_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_RTYPE:     nxt_state = S_EXECUTE;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    OP_J:         nxt_state = S_JUMP;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       nxt_state = S_BNE;
`endif
                    default:      nxt_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_SW) begin
                    nxt_state = S_MEMWR;
                end else if (op == OP_LW) begin
                    nxt_state = S_MEMRD;
                end else begin
                    nxt_state = S_FETCH;
                end
            end
            S_MEMRD:   nxt_state = S_MEMWB;
            S_EXECUTE: nxt_state = S_ALUWB;
            S_ADDIEX:  nxt_state = S_ADDIWB;
            default:   nxt_state = S_FETCH;
        endcase
    end

    assign state = cur_state;

    mc_ctrl_decode u_decode (
        .state    (cur_state),
        .reset    (reset),
        .op       (op),
        .zero     (zero),
        .iord     (iord),
        .irwrite  (irwrite),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .pcsrc    (pcsrc),
        .aluop    (aluop),
        .pcen     (pcen),
        .illegal  (illegal)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven bench for mc_controller with hand-computed per-cycle state and control vectors.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       pcen, illegal;
    logic [3:0] state;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen), .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] T_FETCH = 4'd0, T_DEC = 4'd1, T_MEMADR = 4'd2, T_MEMRD = 4'd3,
                           T_MEMWB = 4'd4, T_MEMWR = 4'd5, T_EXEC = 4'd6, T_ALUWB = 4'd7,
                           T_BRANCH = 4'd8, T_ADDIEX = 4'd9, T_ADDIWB = 4'd10, T_JUMP = 4'd11,
                           T_BNE = 4'd12;

    localparam logic [5:0] C_RT = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011,
                           C_BEQ = 6'b000100, C_BNE = 6'b000101, C_ADDI = 6'b001000,
                           C_J = 6'b000010, C_BAD = 6'b111111;

    // {iord,irwrite,memwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,aluop,pcen,illegal}
    localparam logic [14:0] E_FETCH  = {7'b0100000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [14:0] E_RST    = {7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_DEC    = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_DECILL = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    localparam logic [14:0] E_MEMADR = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMRD  = {7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMWB  = {7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_MEMWR  = {7'b1010000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_EXEC   = {7'b0000001, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
    localparam logic [14:0] E_ALUWB  = {7'b0001100, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_BR_T   = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    localparam logic [14:0] E_BR_N   = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
    localparam logic [14:0] E_ADDIWB = {7'b0001000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [14:0] E_JUMP   = {7'b0000000, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0};

    typedef struct {
        logic        rst;
        logic [5:0]  opc;
        logic        z;
        logic [3:0]  exp_state;
        logic [14:0] exp_ctl;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    task automatic add(input logic r, input logic [5:0] o, input logic z,
                       input logic [3:0] s, input logic [14:0] c);
        vec_t v;
        v.rst = r; v.opc = o; v.z = z; v.exp_state = s; v.exp_ctl = c;
        vecs.push_back(v);
    endtask

    function automatic logic [14:0] actual_ctl();
        return {iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, aluop, pcen, illegal};
    endfunction

    task automatic check(input string name, input logic [3:0] es, input logic [14:0] ec);
        n_vec++;
        if (state !== es || actual_ctl() !== ec) begin
            n_err++;
            $display("FAIL %s: state=%0d ctl=%b, required state=%0d ctl=%b",
                     name, state, actual_ctl(), es, ec);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    int  cyc, mw, rw;
    logic done;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        op    = C_LW;
        zero  = 1'b0;

        // reset held two cycles, then lw with junk op in states that ignore it
        add(0, C_LW, 0, T_FETCH, E_RST);
        add(0, C_LW, 0, T_FETCH, E_RST);
        add(1, C_LW, 0, T_FETCH, E_FETCH);
        add(1, C_LW, 1, T_DEC, E_DEC);
        add(1, C_LW, 0, T_MEMADR, E_MEMADR);
        add(1, C_BAD, 1, T_MEMRD, E_MEMRD);
        add(1, C_BAD, 0, T_MEMWB, E_MEMWB);
        // sw
        add(1, C_SW, 0, T_FETCH, E_FETCH);
        add(1, C_SW, 0, T_DEC, E_DEC);
        add(1, C_SW, 0, T_MEMADR, E_MEMADR);
        add(1, C_SW, 0, T_MEMWR, E_MEMWR);
        // beq taken, then not taken
        add(1, C_BEQ, 1, T_FETCH, E_FETCH);
        add(1, C_BEQ, 1, T_DEC, E_DEC);
        add(1, C_BEQ, 1, T_BRANCH, E_BR_T);
        add(1, C_BEQ, 0, T_FETCH, E_FETCH);
        add(1, C_BEQ, 0, T_DEC, E_DEC);
        add(1, C_BEQ, 0, T_BRANCH, E_BR_N);
        // R-type then addi back to back
        add(1, C_RT, 0, T_FETCH, E_FETCH);
        add(1, C_RT, 0, T_DEC, E_DEC);
        add(1, C_RT, 0, T_EXEC, E_EXEC);
        add(1, C_ADDI, 0, T_ALUWB, E_ALUWB);
        add(1, C_ADDI, 0, T_FETCH, E_FETCH);
        add(1, C_ADDI, 0, T_DEC, E_DEC);
        add(1, C_ADDI, 0, T_ADDIEX, E_MEMADR);
        add(1, C_ADDI, 0, T_ADDIWB, E_ADDIWB);
        // illegal opcode
        add(1, C_BAD, 0, T_FETCH, E_FETCH);
        add(1, C_BAD, 0, T_DEC, E_DECILL);
        // bne
        add(1, C_BNE, 0, T_FETCH, E_FETCH);
`ifdef MC_CONTROLLER_BNE_EN
        add(1, C_BNE, 0, T_DEC, E_DEC);
        add(1, C_BNE, 0, T_BNE, E_BR_T);
        add(1, C_BNE, 1, T_FETCH, E_FETCH);
        add(1, C_BNE, 1, T_DEC, E_DEC);
        add(1, C_BNE, 1, T_BNE, E_BR_N);
`else
        add(1, C_BNE, 0, T_DEC, E_DECILL);
`endif
        // lw interrupted by reset in MEMRD
        add(1, C_LW, 0, T_FETCH, E_FETCH);
        add(1, C_LW, 0, T_DEC, E_DEC);
        add(1, C_LW, 0, T_MEMADR, E_MEMADR);
        add(0, C_LW, 0, T_MEMRD, E_RST);
        add(1, C_LW, 0, T_FETCH, E_FETCH);
        add(1, C_J, 0, T_DEC, E_DEC);
        add(1, C_J, 0, T_JUMP, E_JUMP);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst;
            op    = vecs[i].opc;
            zero  = vecs[i].z;
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_ctl);
        end

        // sw latency and single memwrite pulse, with a bounded wait
        @(negedge clk);
        reset = 1'b1;
        op    = C_SW;
        zero  = 1'b0;
        cyc = 0; mw = 0; done = 1'b0;
        check("sw_start", T_FETCH, E_FETCH);
        while (!done && cyc < 10) begin
            if (memwrite) mw++;
            @(posedge clk);
            #1;
            cyc++;
            if (state == T_FETCH) done = 1'b1;
            else @(negedge clk);
        end
        check_int("sw_latency", cyc, 4);
        check_int("sw_memwrite_pulses", mw, 1);

        // reset during EXECUTE of an R-type: no write-back afterwards
        @(negedge clk);
        op = C_RT;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rt_exec", T_EXEC, E_EXEC);
        reset = 1'b0;
        rw = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (regwrite) rw++;
            @(negedge clk);
        end
        #1;
        check("rt_reset_held", T_FETCH, E_RST);
        reset = 1'b1;
        #1;
        check("rt_after_release", T_FETCH, E_FETCH);
        @(posedge clk);
        #1;
        if (regwrite) rw++;
        check_int("rt_no_regwrite", rw, 0);
        check("rt_decode_after_reset", T_DEC, E_DEC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port clk input 1 as the single clock; all state changes on rising edge.
REQ-002 SHALL have port reset input 1; synchronous, active-low (0 = reset), sampled on rising clk only.
REQ-003 SHALL have port op input 6 carrying the instruction opcode from the instruction register.
REQ-004 SHALL have port zero input 1 carrying the ALU zero flag.
REQ-005 SHALL have outputs iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca, each 1 bit: datapath mux selects and enables.
REQ-006 SHALL have outputs alusrcb 2 (00 B, 01 const 4, 10 signimm, 11 signimm<<2), pcsrc 2 (00 ALU result, 01 aluout, 10 jump target), aluop 2 (00 add, 01 sub, 10 funct-decoded).
REQ-007 SHALL have output pcen 1 = pcwrite OR (branch AND branch-condition-met).
REQ-008 SHALL have output illegal 1, pulsed for one cycle when an unsupported opcode is decoded.
REQ-009 SHALL have output state 4 exposing the current FSM state encoding for bench observation.

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-011 FETCH: iord=0, irwrite=1, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1; next DECODE.
REQ-012 DECODE: alusrca=0, alusrcb=11, aluop=00, no enables; next by op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, else -> FETCH with illegal=1.
REQ-013 MEMADR: alusrca=1, alusrcb=10, aluop=00; op 100011 -> MEMRD, 101011 -> MEMWR.
REQ-014 MEMRD: iord=1 -> MEMWB; MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH; MEMWR: iord=1, memwrite=1 -> FETCH.
REQ-015 EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB; ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH.
REQ-016 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, condition = zero -> FETCH.
REQ-017 ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB; ADDIWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
REQ-018 JUMP: pcsrc=10, pcwrite=1 -> FETCH.
REQ-019 Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-020 Unlisted outputs in any state SHALL be 0; all outputs purely state-decoded except pcen (also uses zero) and illegal (uses op in DECODE).
REQ-021 op and zero SHALL be ignored in states where the transition table does not reference them.

Reset
REQ-022 reset=0 at a rising edge SHALL force state to FETCH regardless of current state, including mid-instruction (no partial writes completed afterwards).
REQ-023 While reset=0, outputs SHALL equal the FETCH decode except pcwrite, irwrite and pcen forced 0; illegal=0.
REQ-024 First edge with reset=1 SHALL execute FETCH normally.

Configuration
REQ-025 Macro MC_CONTROLLER_BNE_EN SHALL, when defined, add state BNE: op 000101 from DECODE -> BNE, outputs as BRANCH but condition = NOT zero, 3-cycle latency.
REQ-026 Without MC_CONTROLLER_BNE_EN, op 000101 SHALL be treated as illegal (REQ-012) and no BNE state SHALL exist.

Structure
REQ-027 State enum, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J) and alusrcb/pcsrc/aluop encodings SHALL live in shared package mc_ctrl_pkg; u1/u32-style types from common.svh.
REQ-028 State register and next-state logic in mc_controller; state-to-output table in one combinational sub-module mc_ctrl_decode.

Verification
REQ-029 Reset low 2 cycles then op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 and memtoreg=1 only in MEMWB.
REQ-030 op=101011 -> memwrite=1 for exactly one cycle (MEMWR, iord=1), back in FETCH 4 cycles after start.
REQ-031 op=000100 with zero=1 -> pcen=1 in BRANCH with pcsrc=01; repeat with zero=0 -> pcen=0 in BRANCH.
REQ-032 op=000000 then op=001000 back-to-back -> ALUWB regdst=1, ADDIWB regdst=0; each 4 cycles.
REQ-033 op=111111 -> illegal=1 one cycle in DECODE, next state FETCH; op=000101 -> illegal without macro, BNE with zero=0 gives pcen=1 with macro.
REQ-034 reset=0 asserted during MEMRD of lw -> next state FETCH, no regwrite pulse observed.
